id_ex_stage: RTL and testbench

ID/EX pipeline stage that registers decoded operands and control from the decode stage and presents `a`, `b` and `op` to the execute-stage ALU. It resolves read-after-write hazards by forwarding EX/MEM and MEM/WB results and by inserting one-cycle load-use bubbles. It also honours downstream stall and branch flush. It sits between the register-file read and the ALU.

---
 rtl/id_ex_stage_pkg.sv | 31 +++
 rtl/id_ex_stage_fwd_mux.sv | 44 ++++
 rtl/id_ex_stage.sv | 159 +++++++++++++++
 tb/tb_id_ex_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: forward-select encoding and bubble defaults.
// DSIZE and ALU opcodes normally come from the project define file; the guards below supply fallbacks.
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif

package id_ex_stage_pkg;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam logic       BUBBLE_VALID    = 1'b0;
    localparam logic       BUBBLE_REGWRITE = 1'b0;
    localparam logic       BUBBLE_MEMREAD  = 1'b0;
    localparam logic [2:0] BUBBLE_ALUOP    = `ALU_ADD;

    // EX/MEM is the younger result, so it wins when both stages hit.
    function automatic logic [1:0] fwd_select(input logic exmem_hit, input logic memwb_hit);
        if (exmem_hit) begin
            return FWD_EXMEM;
        end else if (memwb_hit) begin
            return FWD_MEMWB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forward select and data mux for the ID/EX stage.
// Only built when EX_FORWARD_EN is defined; without it the stage has no forward paths.
`ifndef DSIZE
`define DSIZE 16
`endif

`ifdef EX_FORWARD_EN
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DSIZE = `DSIZE,
    parameter int AW    = 4
) (
    input  logic [AW-1:0]    rs,
    input  logic [DSIZE-1:0] rdata,
    input  logic [AW-1:0]    exmem_rd,
    input  logic             exmem_regwrite,
    input  logic [DSIZE-1:0] exmem_result,
    input  logic [AW-1:0]    memwb_rd,
    input  logic             memwb_regwrite,
    input  logic [DSIZE-1:0] memwb_result,
    output logic [DSIZE-1:0] data
);

    logic       exmem_hit;
    logic       memwb_hit;
    logic [1:0] sel;

    // Register 0 is hardwired, so a write to it must never be forwarded.
    assign exmem_hit = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs);
    assign memwb_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs);
    assign sel       = fwd_select(exmem_hit, memwb_hit);

    always_comb begin
        data = rdata;
        case (sel)
            FWD_EXMEM: data = exmem_result;
            FWD_MEMWB: data = memwb_result;
            default:   data = rdata;
        endcase
    end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW hazard handling, stall hold and branch flush.
// EX_FORWARD_EN selects EX/MEM + MEM/WB forwarding; otherwise any RAW in EX or EX/MEM stalls.
`ifndef DSIZE
`define DSIZE 16
`endif

module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DSIZE = `DSIZE,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [DSIZE-1:0] id_rdata1,
    input  logic [DSIZE-1:0] id_rdata2,
    input  logic [DSIZE-1:0] id_imm,
    input  logic             id_alusrc,
    input  logic [2:0]       id_aluop,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic [AW-1:0]    exmem_rd,
    input  logic             exmem_regwrite,
    input  logic [DSIZE-1:0] exmem_result,
    input  logic [AW-1:0]    memwb_rd,
    input  logic             memwb_regwrite,
    input  logic [DSIZE-1:0] memwb_result,
    input  logic             ex_stall,
    input  logic             flush,
    output logic [DSIZE-1:0] alu_a,
    output logic [DSIZE-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic [DSIZE-1:0] ex_wdata,
    output logic             ex_valid,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic [AW-1:0]    ex_rd
);

    logic             valid_q;
    logic [DSIZE-1:0] rdata1_q;
    logic [DSIZE-1:0] rdata2_q;
    logic [DSIZE-1:0] imm_q;
    logic             alusrc_q;
    logic [2:0]       aluop_q;
    logic [AW-1:0]    rs1_q;
    logic [AW-1:0]    rs2_q;
    logic [AW-1:0]    rd_q;
    logic             regwrite_q;
    logic             memread_q;

    logic             ex_match;
    logic             hazard;
    logic [DSIZE-1:0] fwd1;
    logic [DSIZE-1:0] fwd2;

    // rs2 only counts as a source when it feeds operand b.
    assign ex_match = (rd_q == id_rs1) || ((rd_q == id_rs2) && !id_alusrc);

`ifdef EX_FORWARD_EN
    assign hazard = id_valid && valid_q && memread_q && (rd_q != '0) && ex_match;

    fwd_mux #(.DSIZE(DSIZE), .AW(AW)) u_fwd_rs1 (
        .rs             (rs1_q),
        .rdata          (rdata1_q),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_result   (exmem_result),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_result   (memwb_result),
        .data           (fwd1)
    );

    fwd_mux #(.DSIZE(DSIZE), .AW(AW)) u_fwd_rs2 (
        .rs             (rs2_q),
        .rdata          (rdata2_q),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_result   (exmem_result),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_result   (memwb_result),
        .data           (fwd2)
    );
`else
    logic exmem_match;
    logic unused_nofwd;

    assign exmem_match = (exmem_rd == id_rs1) || ((exmem_rd == id_rs2) && !id_alusrc);
    // MEM/WB needs no check: the register file writes through to the read port.
    assign hazard = id_valid &&
                    ((valid_q && regwrite_q && (rd_q != '0) && ex_match) ||
                     (exmem_regwrite && (exmem_rd != '0) && exmem_match));

    assign fwd1 = rdata1_q;
    assign fwd2 = rdata2_q;
    assign unused_nofwd = ^{rs1_q, rs2_q, exmem_result, memwb_rd, memwb_regwrite, memwb_result};
`endif

    assign id_ready = !ex_stall && !hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= BUBBLE_VALID;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
            aluop_q    <= BUBBLE_ALUOP;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            regwrite_q <= BUBBLE_REGWRITE;
            memread_q  <= BUBBLE_MEMREAD;
        end else if (ex_stall) begin
            valid_q    <= valid_q;
        end else if (flush || hazard) begin
            valid_q    <= BUBBLE_VALID;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
            aluop_q    <= BUBBLE_ALUOP;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            regwrite_q <= BUBBLE_REGWRITE;
            memread_q  <= BUBBLE_MEMREAD;
        end else begin
            valid_q    <= id_valid;
            rdata1_q   <= id_rdata1;
            rdata2_q   <= id_rdata2;
            imm_q      <= id_imm;
            alusrc_q   <= id_alusrc;
            aluop_q    <= id_aluop;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rd_q       <= id_rd;
            regwrite_q <= id_regwrite;
            memread_q  <= id_memread;
        end
    end

    assign alu_a       = fwd1;
    assign alu_b       = alusrc_q ? imm_q : fwd2;
    assign ex_wdata    = fwd2;
    assign alu_op      = aluop_q;
    assign ex_valid    = valid_q;
    assign ex_regwrite = regwrite_q;
    assign ex_memread  = memread_q;
    assign ex_rd       = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage; EX_FORWARD_EN selects which hazard scenarios run.
`timescale 1ns/1ps
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif

module tb_id_ex_stage;

    localparam int DW = `DSIZE;
    localparam int AW = 4;
    localparam int EW = 3 + AW + 3 + 3 * DW;
    localparam logic [2:0] OP_ADD = `ALU_ADD;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          id_valid, id_ready, id_alusrc, id_regwrite, id_memread;
    logic [DW-1:0] id_rdata1, id_rdata2, id_imm;
    logic [2:0]    id_aluop;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic [AW-1:0] exmem_rd, memwb_rd;
    logic          exmem_regwrite, memwb_regwrite;
    logic [DW-1:0] exmem_result, memwb_result;
    logic          ex_stall, flush;
    logic [DW-1:0] alu_a, alu_b, ex_wdata;
    logic [2:0]    alu_op;
    logic          ex_valid, ex_regwrite, ex_memread;
    logic [AW-1:0] ex_rd;

    id_ex_stage #(.DSIZE(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_aluop(id_aluop),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
        .ex_stall(ex_stall), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_wdata(ex_wdata),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd)
    );

    // scoreboard
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs, exp_v, bubble_v;
    int tests = 0;
    int fails = 0;

    function automatic logic [EW-1:0] pack(input logic v, input logic rw, input logic mr,
                                           input logic [AW-1:0] rd, input logic [2:0] op,
                                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] wd);
        return {v, rw, mr, rd, op, a, b, wd};
    endfunction

    // driver tasks
    task automatic drive(input logic v, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                         input logic [DW-1:0] imm, input logic alusrc, input logic [2:0] op,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic rw, input logic mr);
        id_valid = v; id_rdata1 = r1; id_rdata2 = r2; id_imm = imm; id_alusrc = alusrc;
        id_aluop = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic clear_fwd();
        exmem_rd = '0; exmem_regwrite = 1'b0; exmem_result = '0;
        memwb_rd = '0; memwb_regwrite = 1'b0; memwb_result = '0;
    endtask

    // Expected EX contents when the current decode fields are loaded with no forward active.
    task automatic push_issue();
        exp_q.push_back(pack(id_valid, id_regwrite, id_memread, id_rd, id_aluop, id_rdata1,
                             id_alusrc ? id_imm : id_rdata2, id_rdata2));
    endtask

    task automatic sample();
        obs = {ex_valid, ex_regwrite, ex_memread, ex_rd, alu_op, alu_a, alu_b, ex_wdata};
        if (exp_q.size() == 0) exp_v = 'x;
        else exp_v = exp_q.pop_front();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic test_reset();
        drive(0, '0, '0, '0, 0, OP_ADD, '0, '0, '0, 0, 0);
        clear_fwd();
        ex_stall = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        exp_q.push_back(bubble_v);
        sample();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(1, DW'($urandom), DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), AW'($urandom_range(8, 15)), AW'($urandom_range(8, 15)),
                  AW'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), 0);
            #1;
            tests++;
            if (id_ready !== 1'b1) begin
                fails++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, id_ready);
            end
            push_issue();
            tick();
            tests++;
            if (obs !== exp_v) begin
                fails++; $display("FAIL b2b_out[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

`ifdef EX_FORWARD_EN
    task automatic test_forward();
        drive(1, 16'h1111, '0, 16'h0007, 0, 3'd1, 4'd3, 4'd0, 4'd9, 0, 0);
        push_issue();
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL fwd_issue: got %h expected %h", obs, exp_v);
        end
        exmem_rd = 4'd3; exmem_regwrite = 1; exmem_result = 16'h0042;
        memwb_rd = 4'd3; memwb_regwrite = 1; memwb_result = 16'h0099;
        #1;
        tests++;
        if (alu_a !== 16'h0042) begin
            fails++; $display("FAIL fwd_exmem_prio: got %h expected 0042", alu_a);
        end
        exmem_rd = 4'd0; exmem_result = 16'h1234; memwb_regwrite = 0;
        #1;
        tests++;
        if (alu_b !== 16'h0000 || alu_a !== 16'h1111) begin
            fails++; $display("FAIL fwd_r0_guard: got a=%h b=%h expected a=1111 b=0000", alu_a, alu_b);
        end
        memwb_regwrite = 1;
        #1;
        tests++;
        if (alu_a !== 16'h0099) begin
            fails++; $display("FAIL fwd_memwb: got %h expected 0099", alu_a);
        end
        clear_fwd();
    endtask

    task automatic test_load_use();
        drive(1, 16'h0010, 16'h0020, 16'h0004, 1, OP_ADD, 4'd1, 4'd2, 4'd5, 1, 1);
        push_issue();
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL lu_load: got %h expected %h", obs, exp_v);
        end
        drive(1, 16'h5555, 16'h0003, 16'h0000, 0, 3'd2, 4'd5, 4'd6, 4'd7, 1, 0);
        #1;
        tests++;
        if (id_ready !== 1'b0) begin
            fails++; $display("FAIL lu_ready_low: got %b expected 0", id_ready);
        end
        exp_q.push_back(bubble_v);
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL lu_bubble: got %h expected %h", obs, exp_v);
        end
        memwb_rd = 4'd5; memwb_regwrite = 1; memwb_result = 16'hbeef;
        #1;
        tests++;
        if (id_ready !== 1'b1) begin
            fails++; $display("FAIL lu_ready_high: got %b expected 1", id_ready);
        end
        exp_q.push_back(pack(1, 1, 0, 4'd7, 3'd2, 16'hbeef, 16'h0003, 16'h0003));
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL lu_consume: got %h expected %h", obs, exp_v);
        end
        clear_fwd();
    endtask
`else
    task automatic test_raw_stall();
        drive(1, 16'h00aa, 16'h00bb, 16'h0001, 1, 3'd1, 4'd9, 4'd10, 4'd2, 1, 0);
        push_issue();
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL raw_producer: got %h expected %h", obs, exp_v);
        end
        drive(1, 16'h0c0c, 16'h0d0d, 16'h0000, 0, 3'd4, 4'd2, 4'd11, 4'd12, 0, 0);
        #1;
        tests++;
        if (id_ready !== 1'b0) begin
            fails++; $display("FAIL raw_ex_ready: got %b expected 0", id_ready);
        end
        exp_q.push_back(bubble_v);
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL raw_ex_bubble: got %h expected %h", obs, exp_v);
        end
        exmem_rd = 4'd2; exmem_regwrite = 1; exmem_result = 16'h7777;
        #1;
        tests++;
        if (id_ready !== 1'b0) begin
            fails++; $display("FAIL raw_exmem_ready: got %b expected 0", id_ready);
        end
        exp_q.push_back(bubble_v);
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL raw_exmem_bubble: got %h expected %h", obs, exp_v);
        end
        clear_fwd();
        #1;
        tests++;
        if (id_ready !== 1'b1) begin
            fails++; $display("FAIL raw_release: got %b expected 1", id_ready);
        end
        push_issue();
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL raw_consume: got %h expected %h", obs, exp_v);
        end
    endtask
`endif

    task automatic test_stall_flush();
        logic [EW-1:0] x_exp;
        drive(1, 16'h1357, 16'h2468, 16'h0ff0, 1, 3'd5, 4'd8, 4'd9, 4'd3, 0, 0);
        x_exp = pack(1, 0, 0, 4'd3, 3'd5, 16'h1357, 16'h0ff0, 16'h2468);
        exp_q.push_back(x_exp);
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL sf_issue: got %h expected %h", obs, exp_v);
        end
        drive(1, 16'h4321, 16'h8765, 16'h0010, 0, 3'd6, 4'd10, 4'd11, 4'd4, 1, 0);
        ex_stall = 1; flush = 1;
        #1;
        tests++;
        if (id_ready !== 1'b0) begin
            fails++; $display("FAIL sf_ready_stall: got %b expected 0", id_ready);
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(x_exp);
            tick();
            tests++;
            if (obs !== exp_v) begin
                fails++; $display("FAIL sf_hold[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        ex_stall = 0;
        #1;
        tests++;
        if (id_ready !== 1'b1) begin
            fails++; $display("FAIL sf_ready_flush: got %b expected 1", id_ready);
        end
        exp_q.push_back(bubble_v);
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL sf_flush: got %h expected %h", obs, exp_v);
        end
        flush = 0;
        push_issue();
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL sf_resume: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_idle();
        // EX holds a regwrite to r4; an invalid decode naming r4 must not stall.
        drive(0, 16'h0a0a, 16'h0b0b, 16'h0c0c, 0, 3'd3, 4'd4, 4'd4, 4'd6, 0, 0);
        #1;
        tests++;
        if (id_ready !== 1'b1) begin
            fails++; $display("FAIL idle_ready: got %b expected 1", id_ready);
        end
        push_issue();
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL idle_load: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1, 16'h0f0f, 16'hf0f0, 16'h0001, 0, 3'd7, 4'd12, 4'd13, 4'd14, 1, 0);
        push_issue();
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL mid_issue: got %h expected %h", obs, exp_v);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(bubble_v);
        sample();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL mid_reset: got %h expected %h", obs, exp_v);
        end
        drive(0, '0, '0, '0, 0, OP_ADD, '0, '0, '0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        exp_q.push_back(bubble_v);
        tick();
        tests++;
        if (obs !== exp_v) begin
            fails++; $display("FAIL mid_after: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bubble_v = pack(0, 0, 0, '0, OP_ADD, '0, '0, '0);
        test_reset();
        test_back_to_back();
`ifdef EX_FORWARD_EN
        test_forward();
        test_load_use();
`else
        test_raw_stall();
`endif
        test_stall_flush();
        test_idle();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
